hazard_unit: RTL and testbench

Pipeline hazard controller for the five-stage RISC-V core. Generates forwarding selects for the Execute-stage ALU operands, load-use stalls, branch-taken flushes and a hold sequence for a multi-cycle Execute unit (MUL/DIV). It also keeps saturating stall and flush counters for performance monitoring. It sits beside the datapath and takes register addresses and control bits from the D/E/M/W pipeline registers.

---
 rtl/hazard_pkg.sv | 13 +
 rtl/forwarding_unit.sv | 20 ++
 rtl/hazard_unit.sv | 142 ++++++++++++++
 tb/tb_hazard_unit.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package hazard_pkg;

  typedef enum logic [0:0] {
    RUN  = 1'b0,
    WAIT = 1'b1
  } state_e;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

endpackage

// File: rtl/forwarding_unit.sv
// Execute-stage operand forwarding select for one ALU source register.
module forwarding_unit
  import hazard_pkg::*;
(
  input  logic [4:0] rs_e,
  input  logic [4:0] rd_m,
  input  logic [4:0] rd_w,
  input  logic       reg_write_m,
  input  logic       reg_write_w,
  output logic [1:0] forward_sel
);

  // Memory is checked last so it wins when both later stages match.
  always_comb begin
    forward_sel = FWD_RF;
    if (reg_write_w && (rd_w != 5'd0) && (rd_w == rs_e)) forward_sel = FWD_WB;
    if (reg_write_m && (rd_m != 5'd0) && (rd_m == rs_e)) forward_sel = FWD_MEM;
  end

endmodule

// File: rtl/hazard_unit.sv
// Pipeline hazard controller: forwarding, load-use stall, branch flush,
// multi-cycle Execute hold with timeout, and saturating perf counters.
//
// state | meaning
// RUN   | normal flow; a multi-cycle op that is not done enters WAIT
// WAIT  | pipeline held until MulDoneE or the timeout counter expires
module hazard_unit
  import hazard_pkg::*;
#(
  parameter int CNT_W      = 16,
  parameter int MC_TIMEOUT = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       Rs1D,
  input  logic [4:0]       Rs2D,
  input  logic [4:0]       Rs1E,
  input  logic [4:0]       Rs2E,
  input  logic [4:0]       RdE,
  input  logic [4:0]       RdM,
  input  logic [4:0]       RdW,
  input  logic             RegWriteM,
  input  logic             RegWriteW,
  input  logic             ResultSrcE,
  input  logic             PCSrcE,
  input  logic             MulStartE,
  input  logic             MulDoneE,
  output logic [1:0]       ForwardAE,
  output logic [1:0]       ForwardBE,
  output logic             StallF,
  output logic             StallD,
  output logic             StallE,
  output logic             FlushD,
  output logic             FlushE,
  output logic             FlushM,
  output logic             McTimeout,
  output logic [CNT_W-1:0] StallCount,
  output logic [CNT_W-1:0] FlushCount
);

  localparam int TW = (MC_TIMEOUT > 2) ? $clog2(MC_TIMEOUT) : 1;

  state_e           state_q, state_d;
  logic [TW-1:0]    tcnt_q, tcnt_d;
  logic             mc_timeout_q, mc_timeout_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  logic [1:0] fwd_a, fwd_b;
  logic       lw_stall, timeout, mc_hold;

  forwarding_unit u_fwd_a (
    .rs_e(Rs1E), .rd_m(RdM), .rd_w(RdW),
    .reg_write_m(RegWriteM), .reg_write_w(RegWriteW), .forward_sel(fwd_a)
  );

  forwarding_unit u_fwd_b (
    .rs_e(Rs2E), .rd_m(RdM), .rd_w(RdW),
    .reg_write_m(RegWriteM), .reg_write_w(RegWriteW), .forward_sel(fwd_b)
  );

  assign ForwardAE  = rst ? FWD_RF : fwd_a;
  assign ForwardBE  = rst ? FWD_RF : fwd_b;
  assign McTimeout  = mc_timeout_q;
  assign StallCount = stall_cnt_q;
  assign FlushCount = flush_cnt_q;

  always_comb begin
    lw_stall = ResultSrcE && (RdE != 5'd0) && ((RdE == Rs1D) || (RdE == Rs2D));
    timeout  = (state_q == WAIT) && (tcnt_q == TW'(MC_TIMEOUT - 1));
    mc_hold  = ((state_q == RUN) && MulStartE && !MulDoneE) ||
               ((state_q == WAIT) && !MulDoneE && !timeout);
  end

  always_comb begin
    StallF = 1'b0;
    StallD = 1'b0;
    StallE = 1'b0;
    FlushD = 1'b0;
    FlushE = 1'b0;
    FlushM = 1'b0;
    if (rst) begin
      FlushD = 1'b1;
      FlushE = 1'b1;
      FlushM = 1'b1;
    end else if (mc_hold) begin
      StallF = 1'b1;
      StallD = 1'b1;
      StallE = 1'b1;
      FlushM = 1'b1;
    end else if (PCSrcE) begin
      FlushD = 1'b1;
      FlushE = 1'b1;
    end else if (lw_stall) begin
      StallF = 1'b1;
      StallD = 1'b1;
      FlushE = 1'b1;
    end
  end

  always_comb begin
    state_d      = state_q;
    tcnt_d       = tcnt_q;
    mc_timeout_d = 1'b0;
    case (state_q)
      RUN: begin
        if (MulStartE && !MulDoneE) begin
          state_d = WAIT;
          tcnt_d  = '0;
        end
      end
      WAIT: begin
        tcnt_d = tcnt_q + TW'(1);
        if (MulDoneE || timeout) state_d = RUN;
        mc_timeout_d = !MulDoneE && timeout;
      end
      default: state_d = RUN;
    endcase

    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (StallF && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + CNT_W'(1);
    if (FlushD && (flush_cnt_q != '1)) flush_cnt_d = flush_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= RUN;
      tcnt_q       <= '0;
      mc_timeout_q <= 1'b0;
      stall_cnt_q  <= '0;
      flush_cnt_q  <= '0;
    end else begin
      state_q      <= state_d;
      tcnt_q       <= tcnt_d;
      mc_timeout_q <= mc_timeout_d;
      stall_cnt_q  <= stall_cnt_d;
      flush_cnt_q  <= flush_cnt_d;
    end
  end

endmodule

// File: tb/tb_hazard_unit.sv
// Directed self-checking bench for hazard_unit (4-bit counters, timeout of 8).
module tb_hazard_unit;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
  logic       RegWriteM, RegWriteW, ResultSrcE, PCSrcE, MulStartE, MulDoneE;
  logic [1:0] ForwardAE, ForwardBE;
  logic       StallF, StallD, StallE, FlushD, FlushE, FlushM, McTimeout;
  logic [3:0] StallCount, FlushCount;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  hazard_unit #(.CNT_W(4), .MC_TIMEOUT(8)) dut (
    .clk(clk), .rst(rst),
    .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE),
    .RdM(RdM), .RdW(RdW), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
    .ResultSrcE(ResultSrcE), .PCSrcE(PCSrcE),
    .MulStartE(MulStartE), .MulDoneE(MulDoneE),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
    .StallF(StallF), .StallD(StallD), .StallE(StallE),
    .FlushD(FlushD), .FlushE(FlushE), .FlushM(FlushM),
    .McTimeout(McTimeout), .StallCount(StallCount), .FlushCount(FlushCount)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // stall/flush vector packed as {StallF,StallD,StallE,FlushD,FlushE,FlushM}
  task automatic chk_ctl(input string tag, input logic [5:0] exp);
    chk(tag, {26'd0, StallF, StallD, StallE, FlushD, FlushE, FlushM}, {26'd0, exp});
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    Rs1D = 0; Rs2D = 0; Rs1E = 0; Rs2E = 0; RdE = 0; RdM = 0; RdW = 0;
    RegWriteM = 0; RegWriteW = 0; ResultSrcE = 0; PCSrcE = 0;
    MulStartE = 0; MulDoneE = 0;
  endtask

  initial begin
    rst = 1'b1;
    idle();
    RegWriteM = 1; RdM = 5; Rs1E = 5;
    step();
    step();
    chk_ctl("rst_ctl", 6'b000111);
    chk("rst_fwd_a", ForwardAE, 2'b00);
    chk("rst_stall_cnt", StallCount, 0);
    chk("rst_flush_cnt", FlushCount, 0);
    chk("rst_mc_timeout", McTimeout, 0);
    rst = 1'b0;
    #1;

    // forwarding
    RegWriteW = 1; RdW = 5; Rs2E = 3;
    #1;
    chk("fwd_a_mem_wins", ForwardAE, 2'b10);
    chk("fwd_b_none", ForwardBE, 2'b00);
    chk_ctl("fwd_ctl_idle", 6'b000000);
    RdM = 0;
    #1;
    chk("fwd_a_wb", ForwardAE, 2'b01);
    RdM = 0; RdW = 0; Rs1E = 0;
    #1;
    chk("fwd_a_x0", ForwardAE, 2'b00);
    RegWriteM = 0; RdM = 9; RegWriteW = 1; RdW = 9; Rs2E = 9;
    #1;
    chk("fwd_b_wb_m_nowrite", ForwardBE, 2'b01);
    step();
    chk("cnt_after_fwd", StallCount, 0);

    // load-use, then the load in M forwards
    idle();
    ResultSrcE = 1; RdE = 7; Rs2D = 7;
    #1;
    chk_ctl("lw_stall", 6'b110010);
    step();
    idle();
    RegWriteM = 1; RdM = 7; Rs2E = 7;
    #1;
    chk_ctl("lw_released", 6'b000000);
    chk("lw_fwd_b_mem", ForwardBE, 2'b10);
    chk("lw_stall_cnt", StallCount, 1);

    // branch overrides load-use
    idle();
    ResultSrcE = 1; RdE = 7; Rs1D = 7; PCSrcE = 1;
    #1;
    chk_ctl("branch_over_lw", 6'b000110);
    step();
    idle();
    #1;
    chk("branch_flush_cnt", FlushCount, 1);
    chk("branch_stall_cnt", StallCount, 1);

    // multi-cycle op, done 4 cycles after start
    MulStartE = 1;
    #1;
    chk_ctl("mul_hold_0", 6'b111001);
    for (int i = 1; i < 4; i++) begin
      step();
      PCSrcE = (i == 1);
      #1;
      chk_ctl($sformatf("mul_hold_%0d", i), 6'b111001);
    end
    step();
    PCSrcE = 0; MulDoneE = 1;
    #1;
    chk_ctl("mul_release", 6'b000000);
    step();
    idle();
    #1;
    chk_ctl("mul_after", 6'b000000);
    chk("mul_stall_cnt", StallCount, 5);

    // start and done together: no stall
    MulStartE = 1; MulDoneE = 1;
    #1;
    chk_ctl("mul_same_cycle", 6'b000000);
    step();
    idle();
    #1;
    chk_ctl("mul_same_after", 6'b000000);
    chk("mul_same_cnt", StallCount, 5);

    // timeout: eight hold cycles, then release and a registered pulse
    MulStartE = 1;
    for (int i = 0; i < 8; i++) begin
      #1;
      chk($sformatf("to_hold_%0d", i), StallF, 1'b1);
      chk($sformatf("to_no_pulse_%0d", i), McTimeout, 1'b0);
      step();
    end
    #1;
    chk_ctl("to_release", 6'b000000);
    chk("to_pulse_not_yet", McTimeout, 1'b0);
    step();
    MulStartE = 0;
    #1;
    chk("to_pulse", McTimeout, 1'b1);
    chk_ctl("to_state_run", 6'b000000);
    chk("to_stall_cnt", StallCount, 13);
    step();
    chk("to_pulse_once", McTimeout, 1'b0);

    // reset in WAIT
    MulStartE = 1;
    step();
    chk("wait_stall_cnt", StallCount, 14);
    MulStartE = 0;
    rst = 1;
    #1;
    chk_ctl("rst_in_wait", 6'b000111);
    step();
    rst = 0;
    #1;
    chk_ctl("rst_wait_run", 6'b000000);
    chk("rst_wait_stall_cnt", StallCount, 0);
    chk("rst_wait_flush_cnt", FlushCount, 0);
    step();
    chk("rst_wait_no_pulse", McTimeout, 1'b0);

    // saturation
    ResultSrcE = 1; RdE = 7; Rs1D = 7;
    for (int i = 0; i < 15; i++) step();
    chk("sat_stall_15", StallCount, 15);
    for (int i = 0; i < 5; i++) step();
    chk("sat_stall_20", StallCount, 15);
    chk("sat_flush_zero", FlushCount, 0);
    idle();
    PCSrcE = 1;
    for (int i = 0; i < 20; i++) step();
    chk("sat_flush_20", FlushCount, 15);
    chk("sat_stall_hold", StallCount, 15);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
